// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the road-fighter game controller: state encodings,
// datapath widths and small saturating helpers.
package game_sequencer_pkg;

    localparam int SCORE_W = 16;
    localparam int LIVES_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CRASH = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] value);
        return (value == {SCORE_W{1'b1}}) ? value : value + SCORE_W'(1);
    endfunction

    function automatic logic [LIVES_W-1:0] lives_sat_dec(input logic [LIVES_W-1:0] value);
        return (value == '0) ? value : value - LIVES_W'(1);
    endfunction

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// Free-running prescaler: counts 0..DIV-1 and strobes tick while the count
// sits at its terminal value.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign tick = (cnt_reg == CNT_W'(DIV - 1));

    always_comb begin
        cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game controller: strobe generation gated by game state, lives/score
// bookkeeping and the IDLE -> RUN -> CRASH -> OVER sequence.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int TICK_DIV    = 833333,
    parameter int FAST_DIV    = 416667,
    parameter int DROP_PERIOD = 40,
    parameter int LIVES       = 3,
    parameter int CRASH_TICKS = 90,
    parameter int GRACE_TICKS = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               colision,
    output logic               upsig,
    output logic               upsig_fast,
    output logic               drop,
    output logic               respawn,
    output logic [1:0]         state,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam int DROP_W  = (DROP_PERIOD > 1) ? $clog2(DROP_PERIOD) : 1;
    localparam int CRASH_W = (CRASH_TICKS > 1) ? $clog2(CRASH_TICKS) : 1;
    localparam int GRACE_W = $clog2(GRACE_TICKS + 1);

    // index 0 = base tick, index 1 = fast tick
    logic [1:0] tick_vec;
    logic       base_tick;
    logic       fast_tick;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_div
            tick_divider #(
                .DIV (gi == 0 ? TICK_DIV : FAST_DIV)
            ) u_div (
                .clk   (clk),
                .reset (reset),
                .tick  (tick_vec[gi])
            );
        end
    endgenerate

    assign base_tick = tick_vec[0];
    assign fast_tick = tick_vec[1];

    logic [1:0]         state_reg,     state_next;
    logic [LIVES_W-1:0] lives_reg,     lives_next;
    logic [SCORE_W-1:0] score_reg,     score_next;
    logic [DROP_W-1:0]  drop_cnt_reg,  drop_cnt_next;
    logic [CRASH_W-1:0] crash_cnt_reg, crash_cnt_next;
    logic [GRACE_W-1:0] grace_reg,     grace_next;
    logic               start_q_reg;
    logic               col_q_reg;
    logic               upsig_reg,      upsig_next;
    logic               upsig_fast_reg, upsig_fast_next;
    logic               drop_reg,       drop_next;
    logic               respawn_reg,    respawn_next;
    logic               game_over_reg,  game_over_next;

    logic start_evt;
    logic active;
    logic crash_evt;

    assign start_evt = start & ~start_q_reg;
    assign active    = (state_reg == ST_RUN) & ~pause;
    // Only a fresh overlap counts, and never while paused or inside the grace window.
    assign crash_evt = colision & ~col_q_reg & active & (grace_reg == '0);

    always_comb begin
        state_next      = state_reg;
        lives_next      = lives_reg;
        score_next      = score_reg;
        drop_cnt_next   = drop_cnt_reg;
        crash_cnt_next  = crash_cnt_reg;
        grace_next      = grace_reg;
        upsig_next      = 1'b0;
        upsig_fast_next = 1'b0;
        drop_next       = 1'b0;
        respawn_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_evt) begin
                    state_next    = ST_RUN;
                    lives_next    = LIVES_W'(LIVES);
                    score_next    = '0;
                    grace_next    = '0;
                    drop_cnt_next = '0;
                end
            end
            ST_RUN: begin
                if (crash_evt) begin
                    state_next     = ST_CRASH;
                    lives_next     = lives_sat_dec(lives_reg);
                    crash_cnt_next = '0;
                end else if (active) begin
                    upsig_fast_next = fast_tick;
                    if (base_tick) begin
                        upsig_next = 1'b1;
                        score_next = score_sat_inc(score_reg);
                        if (drop_cnt_reg == DROP_W'(DROP_PERIOD - 1)) begin
                            drop_next     = 1'b1;
                            drop_cnt_next = '0;
                        end else begin
                            drop_cnt_next = drop_cnt_reg + DROP_W'(1);
                        end
                        if (grace_reg != '0) begin
                            grace_next = grace_reg - GRACE_W'(1);
                        end
                    end
                end
            end
            ST_CRASH: begin
                if (base_tick) begin
                    if (crash_cnt_reg == CRASH_W'(CRASH_TICKS - 1)) begin
                        if (lives_reg == '0) begin
                            state_next = ST_OVER;
                        end else begin
                            state_next   = ST_RUN;
                            respawn_next = 1'b1;
                            grace_next   = GRACE_W'(GRACE_TICKS);
                        end
                    end else begin
                        crash_cnt_next = crash_cnt_reg + CRASH_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start_evt) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        game_over_next = (state_next == ST_OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            lives_reg      <= '0;
            score_reg      <= '0;
            drop_cnt_reg   <= '0;
            crash_cnt_reg  <= '0;
            grace_reg      <= '0;
            start_q_reg    <= 1'b0;
            col_q_reg      <= 1'b0;
            upsig_reg      <= 1'b0;
            upsig_fast_reg <= 1'b0;
            drop_reg       <= 1'b0;
            respawn_reg    <= 1'b0;
            game_over_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lives_reg      <= lives_next;
            score_reg      <= score_next;
            drop_cnt_reg   <= drop_cnt_next;
            crash_cnt_reg  <= crash_cnt_next;
            grace_reg      <= grace_next;
            start_q_reg    <= start;
            col_q_reg      <= colision;
            upsig_reg      <= upsig_next;
            upsig_fast_reg <= upsig_fast_next;
            drop_reg       <= drop_next;
            respawn_reg    <= respawn_next;
            game_over_reg  <= game_over_next;
        end
    end

    assign upsig      = upsig_reg;
    assign upsig_fast = upsig_fast_reg;
    assign drop       = drop_reg;
    assign respawn    = respawn_reg;
    assign state      = state_reg;
    assign lives      = lives_reg;
    assign score      = score_reg;
    assign game_over  = game_over_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a per-cycle vector table for the main
// game flow plus hand sequences for grace/pause, coincident crash and reset.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic        colision;
    logic        upsig;
    logic        upsig_fast;
    logic        drop;
    logic        respawn;
    logic [1:0]  state;
    logic [2:0]  lives;
    logic [15:0] score;
    logic        game_over;

    game_sequencer #(
        .TICK_DIV    (4),
        .FAST_DIV    (2),
        .DROP_PERIOD (3),
        .LIVES       (2),
        .CRASH_TICKS (2),
        .GRACE_TICKS (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .colision   (colision),
        .upsig      (upsig),
        .upsig_fast (upsig_fast),
        .drop       (drop),
        .respawn    (respawn),
        .state      (state),
        .lives      (lives),
        .score      (score),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start, pause, col;
        logic        up, upf, drp, rsp;
        logic [1:0]  st;
        logic [2:0]  lv;
        logic [15:0] sc;
        logic        go;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;   // posedges since the last reset release

    function automatic logic [25:0] outs();
        return {upsig, upsig_fast, drop, respawn, state, lives, score, game_over};
    endfunction

    function automatic logic [25:0] pack(vec_t v);
        return {v.up, v.upf, v.drp, v.rsp, v.st, v.lv, v.sc, v.go};
    endfunction

    task automatic add(input int n, input int s, input int p, input int c,
                       input int up, input int uf, input int dr, input int rs,
                       input int st, input int lv, input int sc, input int go);
        vec_t v;
        v.start = 1'(s);  v.pause = 1'(p);  v.col = 1'(c);
        v.up = 1'(up);    v.upf = 1'(uf);   v.drp = 1'(dr); v.rsp = 1'(rs);
        v.st = 2'(st);    v.lv = 3'(lv);    v.sc = 16'(sc); v.go = 1'(go);
        repeat (n) vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %h, want %h", name, cyc, got, want);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_pulse;
        int seen;
        logic [15:0] held_score;

        // Output packing: {upsig, upsig_fast, drop, respawn, state, lives, score, game_over}
        add(20, 0,0,0, 0,0,0,0, 0,0,0,0);   // 1-20 idle
        add(1,  1,0,0, 0,0,0,0, 1,2,0,0);   // 21 start
        add(1,  0,0,0, 0,1,0,0, 1,2,0,0);   // 22
        add(1,  0,0,0, 0,0,0,0, 1,2,0,0);   // 23
        add(1,  0,0,0, 1,1,0,0, 1,2,1,0);   // 24
        add(1,  0,0,0, 0,0,0,0, 1,2,1,0);   // 25
        add(1,  0,0,0, 0,1,0,0, 1,2,1,0);   // 26
        add(1,  0,0,0, 0,0,0,0, 1,2,1,0);   // 27
        add(1,  0,0,0, 1,1,0,0, 1,2,2,0);   // 28
        add(1,  0,0,0, 0,0,0,0, 1,2,2,0);   // 29
        add(1,  0,0,0, 0,1,0,0, 1,2,2,0);   // 30
        add(1,  0,0,0, 0,0,0,0, 1,2,2,0);   // 31
        add(1,  0,0,0, 1,1,1,0, 1,2,3,0);   // 32 third upsig -> drop
        add(1,  0,0,0, 0,0,0,0, 1,2,3,0);   // 33
        add(1,  0,0,0, 0,1,0,0, 1,2,3,0);   // 34
        add(1,  0,0,0, 0,0,0,0, 1,2,3,0);   // 35
        add(1,  0,0,0, 1,1,0,0, 1,2,4,0);   // 36
        add(7,  0,0,1, 0,0,0,0, 2,1,4,0);   // 37-43 crash, colision held
        add(1,  0,0,1, 0,0,0,1, 1,1,4,0);   // 44 respawn
        add(1,  0,0,1, 0,0,0,0, 1,1,4,0);   // 45
        add(1,  0,0,1, 0,1,0,0, 1,1,4,0);   // 46
        add(1,  0,0,1, 0,0,0,0, 1,1,4,0);   // 47
        add(1,  0,0,1, 1,1,0,0, 1,1,5,0);   // 48 grace 2->1
        add(1,  0,0,0, 0,0,0,0, 1,1,5,0);   // 49
        add(1,  0,0,1, 0,1,0,0, 1,1,5,0);   // 50 edge inside grace
        add(1,  0,0,1, 0,0,0,0, 1,1,5,0);   // 51
        add(1,  0,0,1, 1,1,1,0, 1,1,6,0);   // 52 grace 1->0
        add(1,  0,0,0, 0,0,0,0, 1,1,6,0);   // 53
        add(6,  0,0,1, 0,0,0,0, 2,0,6,0);   // 54-59 second crash
        add(1,  0,0,1, 0,0,0,0, 3,0,6,1);   // 60 over
        add(3,  0,0,0, 0,0,0,0, 3,0,6,1);   // 61-63
        add(1,  1,0,0, 0,0,0,0, 0,0,6,0);   // 64 start -> idle
        add(3,  0,0,0, 0,0,0,0, 0,0,6,0);   // 65-67
        add(1,  1,0,0, 0,0,0,0, 1,2,0,0);   // 68 new game
        add(1,  0,0,0, 0,0,0,0, 1,2,0,0);   // 69
        add(1,  0,0,0, 0,1,0,0, 1,2,0,0);   // 70
        add(1,  0,0,0, 0,0,0,0, 1,2,0,0);   // 71
        add(1,  0,0,0, 1,1,0,0, 1,2,1,0);   // 72
        add(3,  0,1,0, 0,0,0,0, 1,2,1,0);   // 73-75 paused
        add(9,  0,1,1, 0,0,0,0, 1,2,1,0);   // 76-84 paused, colision edge ignored
        add(1,  0,0,1, 0,0,0,0, 1,2,1,0);   // 85
        add(1,  0,0,1, 0,1,0,0, 1,2,1,0);   // 86
        add(1,  0,0,1, 0,0,0,0, 1,2,1,0);   // 87
        add(1,  0,0,1, 1,1,0,0, 1,2,2,0);   // 88 back in phase
        add(1,  0,0,1, 0,0,0,0, 1,2,2,0);   // 89
        add(1,  0,0,0, 0,1,0,0, 1,2,2,0);   // 90
        add(1,  0,0,0, 0,0,0,0, 1,2,2,0);   // 91
        add(1,  0,0,0, 1,1,1,0, 1,2,3,0);   // 92
        add(1,  0,0,0, 0,0,0,0, 1,2,3,0);   // 93
        add(1,  0,0,0, 0,1,0,0, 1,2,3,0);   // 94

        reset = 1'b0; start = 1'b0; pause = 1'b0; colision = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(outs()), 32'd0);
        reset = 1'b1;
        cyc   = 0;

        foreach (vecs[i]) begin
            start    = vecs[i].start;
            pause    = vecs[i].pause;
            colision = vecs[i].col;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(pack(vecs[i])));
        end

        // Crash edge lands on the same posedge as a base tick.
        while (cyc % 4 != 3) tick();
        colision = 1'b1;
        tick();
        check("crash_on_tick", 32'(outs()), 32'({4'b0000, 2'd2, 3'd1, 16'd3, 1'b0}));
        repeat (2) tick();
        check("crash_hold_state", 32'(state), 32'd2);

        // Asynchronous reset in the middle of CRASH.
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", 32'(outs()), 32'd0);
        colision = 1'b0;
        n_pulse  = 0;
        repeat (4) begin
            tick();
            n_pulse += int'(upsig) + int'(upsig_fast) + int'(drop) + int'(respawn);
        end
        check("reset_hold", 32'({outs(), 6'd0}) | 32'(n_pulse), 32'd0);
        reset = 1'b1;
        cyc   = 0;

        // Grace window is frozen by pause.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart", 32'({state, lives, score}), 32'({2'd1, 3'd2, 16'd0}));
        colision = 1'b1;
        tick();
        colision = 1'b0;
        check("crash1", 32'({state, lives}), 32'({2'd2, 3'd1}));
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            tick();
            if (respawn) seen = 1;
        end
        check("respawn_seen", 32'(seen), 32'd1);
        check("respawn_cyc", 32'(cyc), 32'd8);
        pause   = 1'b1;
        n_pulse = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 5) colision = 1'b1;
            if (i == 9) colision = 1'b0;
            tick();
            n_pulse += int'(upsig) + int'(upsig_fast) + int'(drop);
        end
        check("pause_pulses", 32'(n_pulse), 32'd0);
        check("pause_state", 32'(state), 32'd1);
        pause = 1'b0;
        while (cyc < 24) tick();
        colision = 1'b1;
        tick();
        colision = 1'b0;
        check("grace_after_pause", 32'({state, lives}), 32'({2'd1, 3'd1}));
        while (cyc < 28) tick();
        colision = 1'b1;
        tick();
        colision = 1'b0;
        check("crash2", 32'({state, lives, score}), 32'({2'd2, 3'd0, 16'd2}));
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            tick();
            if (game_over) seen = 1;
        end
        check("over_seen", 32'({seen[0], state}), 32'({1'b1, 2'd3}));
        held_score = score;
        repeat (8) tick();
        check("over_score_hold", 32'({score, lives}), 32'({held_score, 3'd0}));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("over_to_idle", 32'({state, game_over}), 32'({2'd0, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
